// File: rtl/mdu_unit.sv
// Multiply/divide unit owning HI/LO; results computed at issue, committed after MULT_CYCLES/DIV_CYCLES.
// Latency: mult/multu/div/divu commit on the edge that ends the Nth busy cycle; mthi/mtlo write on the next edge.
// Backpressure: busy blocks new ops (ignored while busy); optional MDU_REQ_EN adds req to suppress start.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_REQ_EN
    input  logic        req,
`endif
    input  logic [3:0]  start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MFHI  = 4'b0111;
    localparam logic [3:0] OP_MFLO  = 4'b1000;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } pend_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    pend_t       pend_q, pend_d;
    logic [31:0] hi_d, lo_d;
    logic [3:0]  op;

`ifdef MDU_REQ_EN
    assign op = req ? OP_NONE : start;
`else
    assign op = start;
`endif

    assign busy = (state_q == ST_BUSY);

    // Single 64x64 multiplier; sign/zero extension selects mult vs multu, low 64 bits are exact.
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, product;

    assign mul_signed = (op == OP_MULT);
    assign mul_a      = {{32{mul_signed & A[31]}}, A};
    assign mul_b      = {{32{mul_signed & B[31]}}, B};
    assign product    = mul_a * mul_b;

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
    logic        div_signed, a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed & A[31];
    assign b_neg      = div_signed & B[31];
    assign a_mag      = a_neg ? (32'd0 - A) : A;
    assign b_mag      = b_neg ? (32'd0 - B) : B;
    assign div_zero   = (B == 32'd0);
    assign b_safe     = div_zero ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign quo        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = HI;
        lo_d    = LO;
        case (state_q)
            ST_IDLE: begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        pend_d  = '{hi: product[63:32], lo: product[31:0], wr: 1'b1};
                        cnt_d   = MULT_N;
                        state_d = ST_BUSY;
                    end
                    OP_DIV, OP_DIVU: begin
                        pend_d  = '{hi: rem, lo: quo, wr: !div_zero};
                        cnt_d   = DIV_N;
                        state_d = ST_BUSY;
                    end
                    OP_MTHI: hi_d = A;
                    OP_MTLO: lo_d = A;
                    default: ;
                endcase
            end
            ST_BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    pend_d  = '0;
                    if (pend_q.wr) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= '0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            HI      <= hi_d;
            LO      <= lo_d;
        end
    end

    always_comb begin
        MDout = 32'd0;
        case (op)
            OP_MFHI: MDout = HI;
            OP_MFLO: MDout = LO;
            default: ;
        endcase
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multiply/divide unit in the E stage of the 5-stage pipeline. It executes mult/multu/div/divu/mthi/mtlo/mfhi/mflo from a 4-bit start code and owns the HI/LO registers. It drives the busy signal that the hazard unit uses, together with the start code, to stall MD-class instructions in D. Results are computed on issue and committed to HI/LO after a fixed per-operation latency.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  4  E-stage op code: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 mfhi, 1000 mflo; 1001-1111 treated as none
A  input  32  rs operand, already forwarded
B  input  32  rt operand, already forwarded
busy  output  1  multi-cycle operation in progress
HI  output  32  architectural HI register
LO  output  32  architectural LO register
MDout  output  32  mfhi -> HI, mflo -> LO, else 0 (combinational)

Behaviour:
- Reset at a clk edge with reset=1: HI=0, LO=0, busy=0, counter=0, pending result cleared. Any in-flight operation is aborted and its result is never committed. Reset has priority over every other input.
- Issue: ops 0001-0100 are accepted only when busy=0. On the accepting edge:
  - the full 64-bit result is latched into pending HI/LO registers;
  - counter is loaded with MULT_CYCLES or DIV_CYCLES;
  - busy goes to 1.
- Timing for an issue in cycle t: busy=1 in cycles t+1..t+N. The counter decrements each edge. The edge that takes the counter from 1 to 0 writes the pending values to HI/LO and clears busy. New HI/LO are therefore visible in cycle t+N+1, the same cycle busy reads 0.
- mult: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
- multu: the same, with both operands unsigned.
- div: signed. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend A.
  - A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0, div or divu): busy still asserts for DIV_CYCLES; HI and LO stay unchanged at completion.
- mthi/mtlo: accepted only when busy=0. HI (or LO) <= A on the next edge; there is no busy cycle.
- mfhi/mflo: combinational read via MDout; no state change. If busy=1, MDout returns the old HI/LO; the hazard unit prevents this case.
- Any start code (ops 0001-0110) arriving while busy=1 is ignored. It does not restart, extend or corrupt the current operation.
- Back-to-back: an op issued in the first cycle busy=0 after completion is accepted normally. It computes from the already-committed HI/LO state.
- Combinational outputs: busy, HI and LO are registered outputs; MDout is combinational.

Optional Feature:
MDU_REQ_EN: adds input port req (1 bit, placed after reset), the interrupt/exception request from the CP0 path.
- With MDU_REQ_EN: while req=1, any start code in that cycle is suppressed. It causes no issue, no mthi/mtlo write and no busy. An operation already in flight is not affected and completes normally.
- Without MDU_REQ_EN: the req port does not exist and start is always honoured under the rules above.

Test Plan:
- reset=1 for 2 cycles with start=0001 applied -> busy=0, HI=0, LO=0 after release.
- mult A=0xFFFFFFFE (-2), B=3 at cycle t -> busy=1 for t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=-7 (0xFFFFFFF9), B=2 -> 10 busy cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Re-issue during busy: divu A=100, B=7, then mult applied at busy cycle 3 -> mult ignored; final LO=14, HI=2. div with B=0 -> HI/LO unchanged after 10 busy cycles.
- mthi A=0x12345678, then mflo/mfhi next cycle -> MDout=LO, then MDout=0x12345678. Reset asserted at busy cycle 4 of mult -> busy=0, HI=LO=0, no later commit. With MDU_REQ_EN, mult issued with req=1 -> busy stays 0 and HI/LO unchanged.
